// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: multi-cycle shift-add multiply / restoring divide with a HI/LO result.
// Operands are latched on start; WIDTH iterations run in RUN, and FIX applies the sign
// correction and publishes hi/lo with a one-cycle done pulse.
// Optional build macro: MULDIV_EARLY_TERM_EN (a multiply ends once the remaining multiplier bits are zero).
module muldiv_seq_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             op_div,
   input  logic             sign,
   input  logic             cancel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);
   localparam int AW = 2*WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;      // mul: {upper+carry, multiplier}; div: {rem, quo}
   logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0] araw_q, araw_d;    // original A, reported as hi on divide-by-zero
   logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_a_q, neg_a_d, dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             div_zero_q, div_zero_d, done_q, done_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum, mul_up;
   logic [AW-1:0]    mul_step, mul_next, div_sh, div_step;
   logic [WIDTH+1:0] div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic             early, skip_run;

   assign a_neg = sign & A[WIDTH-1];
   assign b_neg = sign & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   // one shift-add step: add multiplicand on multiplier LSB, then shift right
   assign mul_sum  = acc_q[AW-1:WIDTH] + {1'b0, opnd_q};
   assign mul_up   = acc_q[0] ? mul_sum : acc_q[AW-1:WIDTH];
   assign mul_step = {mul_up, acc_q[WIDTH-1:0]} >> 1;

   // one restoring step: shift left, keep the trial difference if it did not go negative
   assign div_sh    = {acc_q[AW-2:0], 1'b0};
   assign div_trial = {1'b0, div_sh[AW-1:WIDTH]} - {2'b00, opnd_q};
   assign div_step  = div_trial[WIDTH+1] ? div_sh : {div_trial[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};

`ifdef MULDIV_EARLY_TERM_EN
   // multiplier bits not yet consumed after this step sit in acc_q[cnt_q-1:1]
   logic [WIDTH-1:0] rest_mask;
   assign rest_mask = {WIDTH{1'b1}} >> (WIDTH + 1 - int'(cnt_q));
   assign early     = !is_div_q && (cnt_q > CNT_W'(1)) &&
                      (((acc_q[WIDTH-1:0] >> 1) & rest_mask) == '0);
   assign mul_next  = early ? (mul_step >> (cnt_q - CNT_W'(1))) : mul_step;
   assign skip_run  = !op_div && (b_mag == '0);
`else
   assign early     = 1'b0;
   assign mul_next  = mul_step;
   assign skip_run  = 1'b0;
`endif

   assign prod_fix = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
   assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // next-state: cancel beats start in IDLE and aborts RUN/FIX
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && !cancel) state_d = skip_run ? S_FIX : S_RUN;
         S_RUN:  if (cancel) state_d = S_IDLE;
                 else if (cnt_q == CNT_W'(1) || early) state_d = S_FIX;
         S_FIX:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = done_q;
      hi       = hi_q;
      lo       = lo_q;
      div_zero = div_zero_q;
   end

   // datapath next-state: load on accept, iterate in RUN, publish in FIX
   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      araw_d     = araw_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_a_d    = neg_a_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: if (start && !cancel) begin
            is_div_d  = op_div;
            neg_res_d = a_neg ^ b_neg;
            neg_a_d   = a_neg;
            dz_d      = (B == '0);
            araw_d    = A;
            opnd_d    = op_div ? b_mag : a_mag;
            acc_d     = {{(WIDTH+1){1'b0}}, (op_div ? a_mag : b_mag)};
            cnt_d     = skip_run ? '0 : CNT_W'(WIDTH);
         end
         S_RUN: if (!cancel) begin
            acc_d = is_div_q ? div_step : mul_next;
            cnt_d = early ? '0 : cnt_q - CNT_W'(1);
         end
         S_FIX: if (!cancel) begin
            done_d = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
               div_zero_d   = 1'b0;
            end else if (dz_q) begin
               hi_d       = araw_q;
               lo_d       = '1;
               div_zero_d = 1'b1;
            end else begin
               hi_d       = rem_fix;
               lo_d       = quo_fix;
               div_zero_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         araw_q     <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_a_q    <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         araw_q     <= araw_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_a_q    <= neg_a_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Parametrised, multi-cycle multiply/divide unit. It replaces the single-cycle combinational mult/div instances that currently sit alongside the register file in the decode stage. The unit takes rs/rt operands with a start/busy/done handshake, runs a shift-add multiply or a restoring divide over WIDTH iterations, and holds a 2*WIDTH-bit HI/LO result. The hazard unit stalls dependent mfhi/mflo on busy.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH bits (HI = upper WIDTH, LO = lower WIDTH); must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-low reset
start  input  1  operation request; sampled only in IDLE
op_div  input  1  0 = multiply, 1 = divide; sampled with start
sign  input  1  1 = signed two's-complement, 0 = unsigned; sampled with start
cancel  input  1  pipeline flush; aborts an in-flight operation
A  input  WIDTH  multiplicand / dividend (rs)
B  input  WIDTH  multiplier / divisor (rt)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when hi/lo are updated
hi  output  WIDTH  mult: upper product; div: remainder
lo  output  WIDTH  mult: lower product; div: quotient
div_zero  output  1  sticky with the result: last completed div had B == 0

Behaviour:
- Reset (RST low, asynchronous): state = IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0.
- States:
  - IDLE: start=1 at an edge latches op_div and sign, latches |A| and |B| (magnitudes when sign=1, raw operands otherwise), records the result sign and dividend sign, loads counter = WIDTH, and goes to RUN.
  - RUN: one iteration per edge; counter decrements; goes to FIX on the edge where the counter reaches 0.
  - FIX: applies sign correction, writes hi/lo/div_zero, pulses done, and returns to IDLE.
- Multiply iteration: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half; shift the accumulator right by 1 (carry kept in a WIDTH+1-bit upper half).
- Divide iteration: shift {rem, quo} left by 1; trial-subtract divisor from rem; if the result is non-negative, commit it and set quo LSB.
- Sign correction:
  - Multiply: negate the 2*WIDTH product if sign=1 and exactly one operand is negative.
  - Divide: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative (remainder takes the dividend's sign).
- Latency: start high in cycle 0 -> busy high cycles 1..WIDTH+1 -> done high in cycle WIDTH+2, with hi/lo valid from that cycle. busy is low in the done cycle.
- hi/lo hold their values until the next done. They never change mid-operation.
- start while busy: ignored, with no queueing. start in the done cycle is accepted (the state is IDLE).
- cancel: in RUN or FIX, it forces IDLE at the next edge, with no done and no hi/lo/div_zero update. In IDLE, cancel has priority over start, so that start is dropped.
- Divide by zero: takes full latency; lo = all ones, hi = A (original, uncorrected), div_zero = 1. A completed multiply or non-zero divide clears div_zero.
- Signed overflow (A = most negative, B = -1, div): lo = most negative, hi = 0, with no flag.
- Reset asserted mid-operation: all state is cleared immediately, and no done is produced.

Optional Feature:
MULDIV_EARLY_TERM_EN:
- Defined: in a multiply RUN, when the remaining multiplier bits are all zero, the unit jumps to FIX after shifting the accumulator the outstanding count in one step. Latency becomes (index of the highest set multiplier-magnitude bit + 1) + 2, with a minimum of 2. A multiplier of 0 takes 2 cycles (done in cycle 2). Divide latency is unchanged.
- Undefined: fixed WIDTH+2 latency for all operations.

Test Plan:
- WIDTH=32: unsigned mult A=0xFFFFFFFF, B=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- Signed mult A=-7 (0xFFFFFFF9), B=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42); unsigned div A=100, B=7 -> lo=14, hi=2.
- Signed div A=-100, B=7 -> lo=-14 (0xFFFFFFF2), hi=-2 (0xFFFFFFFE). Signed div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Div A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1. A following mult 3*3 -> lo=9, div_zero=0.
- Start a mult; in cycle 10 raise cancel together with a second start -> no done pulse, hi/lo keep their previous values. A start in cycle 12 completes in cycle 14+32.
- Pull RST low in cycle 5 of a divide -> busy=0, hi=lo=0 asynchronously; no done pulse. With MULDIV_EARLY_TERM_EN, mult A=5, B=3 -> done in cycle 4, lo=15.
